// File: rtl/com_bus_pkg.sv
// com_bus_pkg: shared arbiter states and bus sizing constants
package com_bus_pkg;
   localparam int NUM_PORTS = 8;
   localparam int NUM_SNOOP = 4;
   localparam int IDX_W = $clog2(NUM_PORTS);
   typedef enum logic [1:0] {IDLE, P_GNT, S_GNT, M_GNT} arb_state_t;
endpackage

// File: rtl/com_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set bit at or above ptr with wrap
module rr_pick #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx
);
   always_comb begin
      idx = '0;
      for (int k = N - 1; k >= 0; k--)
         if (req[(int'(ptr) + k) % N]) idx = W'((int'(ptr) + k) % N);
      gnt = |req ? (N'(1) << idx) : '0;
   end
endmodule

// File: rtl/com_bus_arbiter.sv
// com_bus_arbiter: common-bus request/grant arbiter; ARB_TIMEOUT_EN adds a sticky hold watchdog (arb_timeout)
module com_bus_arbiter
   import com_bus_pkg::*;
#(
   parameter int NUM_PORTS = com_bus_pkg::NUM_PORTS,
   parameter int NUM_SNOOP = com_bus_pkg::NUM_SNOOP,
   parameter int TIMEOUT_CYCLES = 256,
   parameter int W = $clog2(NUM_PORTS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_PORTS-1:0] Com_Bus_Req_proc,
   output logic [NUM_PORTS-1:0] Com_Bus_Gnt_proc,
   input  logic [NUM_PORTS-1:0] Com_Bus_Req_snoop,
   output logic [NUM_PORTS-1:0] Com_Bus_Gnt_snoop,
   input  logic                 Mem_snoop_req,
   output logic                 Mem_snoop_gnt,
   output logic [W-1:0]         bus_owner,
`ifdef ARB_TIMEOUT_EN
   output logic                 arb_timeout,
`endif
   output logic                 bus_busy
);
   localparam logic [NUM_PORTS-1:0] SNOOP_MASK = NUM_PORTS'((1 << NUM_SNOOP) - 1);
   arb_state_t state, state_n;
   logic [W-1:0] ptr, ptr_n, owner_n, pick_idx;
   logic [NUM_PORTS-1:0] pick_gnt, gp_n, gs_n, snoop_v;
   logic mg_n;
   rr_pick #(.N(NUM_PORTS), .W(W)) u_pick (
      .req(Com_Bus_Req_proc),
      .ptr(ptr),
      .gnt(pick_gnt),
      .idx(pick_idx)
   );
   always_comb begin
      state_n = state;
      ptr_n = ptr;
      owner_n = bus_owner;
      gp_n = Com_Bus_Gnt_proc;
      gs_n = Com_Bus_Gnt_snoop;
      mg_n = Mem_snoop_gnt;
      snoop_v = Com_Bus_Req_snoop & SNOOP_MASK & ~(NUM_PORTS'(1) << bus_owner);
      case (state)
         IDLE:
            if (|Com_Bus_Req_proc) begin
               state_n = P_GNT;
               owner_n = pick_idx;
               gp_n = pick_gnt;
            end
         P_GNT:
            if (!Com_Bus_Req_proc[bus_owner]) begin
               state_n = IDLE;
               gp_n = '0;
               ptr_n = (bus_owner == W'(NUM_PORTS - 1)) ? '0 : bus_owner + 1'b1;
            end else if (|snoop_v) begin
               state_n = S_GNT;
               gs_n = snoop_v & (~snoop_v + 1'b1);
            end else if (Mem_snoop_req) begin
               state_n = M_GNT;
               mg_n = 1'b1;
            end
         S_GNT:
            if (!(|(Com_Bus_Gnt_snoop & Com_Bus_Req_snoop))) begin
               state_n = P_GNT;
               gs_n = '0;
            end
         M_GNT:
            if (!Mem_snoop_req) begin
               state_n = P_GNT;
               mg_n = 1'b0;
            end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr <= '0;
         bus_owner <= '0;
         Com_Bus_Gnt_proc <= '0;
         Com_Bus_Gnt_snoop <= '0;
         Mem_snoop_gnt <= 1'b0;
         bus_busy <= 1'b0;
      end else begin
         state <= state_n;
         ptr <= ptr_n;
         bus_owner <= owner_n;
         Com_Bus_Gnt_proc <= gp_n;
         Com_Bus_Gnt_snoop <= gs_n;
         Mem_snoop_gnt <= mg_n;
         bus_busy <= |gp_n;
      end
   end
`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] hold_cnt;
   logic chg;
   assign chg = {gp_n, gs_n, mg_n} != {Com_Bus_Gnt_proc, Com_Bus_Gnt_snoop, Mem_snoop_gnt};
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_cnt <= '0;
         arb_timeout <= 1'b0;
      end else begin
         hold_cnt <= chg ? '0 : (bus_busy && hold_cnt != CW'(TIMEOUT_CYCLES)) ? hold_cnt + 1'b1 : hold_cnt;
         arb_timeout <= arb_timeout | (hold_cnt == CW'(TIMEOUT_CYCLES));
      end
   end
`endif
endmodule

// File: tb/tb_com_bus_arbiter.sv
// tb_com_bus_arbiter: directed self-checking bench for com_bus_arbiter
module tb_com_bus_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] req_proc = '0, gnt_proc, req_snoop = '0, gnt_snoop;
   logic mem_req = 1'b0, mem_gnt, busy;
   logic [2:0] owner;
   int n_pass = 0, n_tot = 0;
`ifdef ARB_TIMEOUT_EN
   logic tmo;
`endif
   always #5 clk = ~clk;
   com_bus_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk),
      .rst(rst),
      .Com_Bus_Req_proc(req_proc),
      .Com_Bus_Gnt_proc(gnt_proc),
      .Com_Bus_Req_snoop(req_snoop),
      .Com_Bus_Gnt_snoop(gnt_snoop),
      .Mem_snoop_req(mem_req),
      .Mem_snoop_gnt(mem_gnt),
      .bus_owner(owner),
`ifdef ARB_TIMEOUT_EN
      .arb_timeout(tmo),
`endif
      .bus_busy(busy)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask
   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      req_proc = '0;
      req_snoop = '0;
      mem_req = 1'b0;
      step();
      rst = 1'b0;
   endtask
   initial begin
      #1;
      do_reset();
      chk("rst_gnt_proc", gnt_proc, 0);
      chk("rst_gnt_snoop", gnt_snoop, 0);
      chk("rst_mem_gnt", mem_gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 0);
      req_proc = 8'h04;
      step();
      chk("single_gnt", gnt_proc, 8'h04);
      chk("single_owner", owner, 2);
      chk("single_busy", busy, 1);
      req_proc = 8'h00;
      step();
      chk("single_drop", gnt_proc, 0);
      chk("idle_owner_hold", owner, 2);
      chk("idle_busy", busy, 0);
      do_reset();
      req_proc = 8'hFF;
      step();
      for (int k = 0; k < 9; k++) begin
         chk($sformatf("rr_gnt%0d", k), gnt_proc, 8'h01 << (k % 8));
         chk($sformatf("rr_own%0d", k), owner, k % 8);
         step(2);
         req_proc[k % 8] = 1'b0;
         step();
         chk($sformatf("rr_dead%0d", k), gnt_proc, 0);
         req_proc[k % 8] = 1'b1;
         step();
      end
      do_reset();
      req_proc = 8'h02;
      step();
      chk("snp_owner", owner, 1);
      req_snoop = 8'h09;
      step();
      chk("snp_first", gnt_snoop, 8'h01);
      chk("snp_proc1", gnt_proc, 8'h02);
      req_snoop = 8'h08;
      step();
      chk("snp_drop0", gnt_snoop, 0);
      chk("snp_proc2", gnt_proc, 8'h02);
      step();
      chk("snp_second", gnt_snoop, 8'h08);
      chk("snp_proc3", gnt_proc, 8'h02);
      req_snoop = 8'h00;
      step();
      chk("snp_done", gnt_snoop, 0);
      req_proc = 8'h00;
      step();
      chk("snp_release", gnt_proc, 0);
      do_reset();
      req_proc = 8'h04;
      step();
      req_snoop = 8'h14;
      step();
      chk("ign_snoop", gnt_snoop, 0);
      chk("ign_mem", mem_gnt, 0);
      mem_req = 1'b1;
      step();
      chk("mem_gnt", mem_gnt, 1);
      chk("mem_no_snoop", gnt_snoop, 0);
      chk("mem_proc", gnt_proc, 8'h04);
      do_reset();
      req_proc = 8'h01;
      step();
      mem_req = 1'b1;
      step();
      chk("def_mem", mem_gnt, 1);
      req_proc = 8'h00;
      step(2);
      chk("def_hold_proc", gnt_proc, 8'h01);
      chk("def_hold_mem", mem_gnt, 1);
      mem_req = 1'b0;
      step();
      chk("def_pgnt_proc", gnt_proc, 8'h01);
      chk("def_pgnt_mem", mem_gnt, 0);
      step();
      chk("def_release", gnt_proc, 0);
      chk("def_busy", busy, 0);
      do_reset();
      req_proc = 8'h02;
      step();
      req_proc = 8'h00;
      step();
      req_proc = 8'h08;
      step();
      chk("mid_owner", owner, 3);
      req_snoop = 8'h01;
      step();
      chk("mid_snoop", gnt_snoop, 8'h01);
      rst = 1'b1;
      step();
      chk("mid_rst_proc", gnt_proc, 0);
      chk("mid_rst_snoop", gnt_snoop, 0);
      chk("mid_rst_owner", owner, 0);
      rst = 1'b0;
      req_snoop = 8'h00;
      req_proc = 8'hFF;
      step();
      chk("mid_rst_ptr", gnt_proc, 8'h01);
`ifdef ARB_TIMEOUT_EN
      do_reset();
      chk("tmo_rst", tmo, 0);
      req_proc = 8'h01;
      step(10);
      chk("tmo_early", tmo, 0);
      step(10);
      chk("tmo_set", tmo, 1);
      req_proc = 8'h00;
      step(3);
      chk("tmo_sticky", tmo, 1);
      do_reset();
      chk("tmo_clear", tmo, 0);
`endif
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
